// File: rtl/vga_timing_pkg.sv
// Raster geometry constants (640x480@60, 800x600@60) and helpers shared by the VGA timing blocks.
// Pure declarations: no logic, no latency, no flow control.
package vga_timing_pkg;

  localparam int VGA640_H_SYNC   = 96;
  localparam int VGA640_H_BP     = 48;
  localparam int VGA640_H_ACTIVE = 640;
  localparam int VGA640_H_FP     = 16;
  localparam int VGA640_V_SYNC   = 2;
  localparam int VGA640_V_BP     = 33;
  localparam int VGA640_V_ACTIVE = 480;
  localparam int VGA640_V_FP     = 10;

  localparam int SVGA800_H_SYNC   = 128;
  localparam int SVGA800_H_BP     = 88;
  localparam int SVGA800_H_ACTIVE = 800;
  localparam int SVGA800_H_FP     = 40;
  localparam int SVGA800_V_SYNC   = 4;
  localparam int SVGA800_V_BP     = 23;
  localparam int SVGA800_V_ACTIVE = 600;
  localparam int SVGA800_V_FP     = 1;

  function automatic int axis_total(input int sync_w, input int bp_w, input int act_w, input int fp_w);
    return sync_w + bp_w + act_w + fp_w;
  endfunction

  // A one-position axis still needs a 1-bit counter.
  function automatic int cnt_width(input int tot);
    return (tot > 1) ? $clog2(tot) : 1;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Modulo-MAX position counter for one raster axis; advances on en, wrap is combinational (en & last).
// Single-cycle update, no backpressure: en is the only qualifier.
module vga_axis_counter #(
  parameter int MAX = 800,
  parameter int W   = 10
) (
  input  logic         vga_clk,
  input  logic         clrn,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  assign wrap = en && (cnt == W'(MAX - 1));

  always_ff @(posedge vga_clk) begin
    if (!clrn) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= wrap ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing: sync, read strobe, RAM address and start pulses, 1+PIPE enabled cycles
// behind the counters. No backpressure; pix_en freezes counters and pipeline, pulses only on enabled cycles.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_SYNC   = VGA640_H_SYNC,
  parameter int H_BP     = VGA640_H_BP,
  parameter int H_ACTIVE = VGA640_H_ACTIVE,
  parameter int H_FP     = VGA640_H_FP,
  parameter int V_SYNC   = VGA640_V_SYNC,
  parameter int V_BP     = VGA640_V_BP,
  parameter int V_ACTIVE = VGA640_V_ACTIVE,
  parameter int V_FP     = VGA640_V_FP,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int COL_W    = 10,
  parameter int ROW_W    = 9,
  parameter int PIPE     = 0
) (
  input  logic             vga_clk,
  input  logic             clrn,
  input  logic             pix_en,
  output logic [ROW_W-1:0] row_addr,
  output logic [COL_W-1:0] col_addr,
  output logic             rdn,
  output logic             hs,
  output logic             vs,
  output logic             line_start,
  output logic             frame_start
);

  localparam int H_TOT = axis_total(H_SYNC, H_BP, H_ACTIVE, H_FP);
  localparam int V_TOT = axis_total(V_SYNC, V_BP, V_ACTIVE, V_FP);
  localparam int HW    = cnt_width(H_TOT);
  localparam int VW    = cnt_width(V_TOT);
  localparam int HA0   = H_SYNC + H_BP;
  localparam int VA0   = V_SYNC + V_BP;

  if (PIPE < 0 || PIPE > 3) begin : g_bad_pipe
    $error("vga_timing_gen: PIPE must be 0..3");
  end
  if ((H_ACTIVE - 1) >= (1 << COL_W)) begin : g_bad_col_w
    $error("vga_timing_gen: COL_W too narrow for H_ACTIVE");
  end
  if ((V_ACTIVE - 1) >= (1 << ROW_W)) begin : g_bad_row_w
    $error("vga_timing_gen: ROW_W too narrow for V_ACTIVE");
  end

  typedef struct packed {
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic             rdn;
    logic             hs;
    logic             vs;
    logic             ls;
    logic             fs;
  } stage_t;

  localparam stage_t STAGE_RST = '{row: '0, col: '0, rdn: 1'b1, hs: ~HS_POL, vs: ~VS_POL,
                                   ls: 1'b0, fs: 1'b0};

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          h_wrap;
  logic          v_wrap_unused;

  vga_axis_counter #(.MAX(H_TOT), .W(HW)) u_h_cnt (
    .vga_clk (vga_clk),
    .clrn    (clrn),
    .en      (pix_en),
    .cnt     (h_cnt),
    .wrap    (h_wrap)
  );

  vga_axis_counter #(.MAX(V_TOT), .W(VW)) u_v_cnt (
    .vga_clk (vga_clk),
    .clrn    (clrn),
    .en      (pix_en & h_wrap),
    .cnt     (v_cnt),
    .wrap    (v_wrap_unused)
  );

  int     h_i;
  int     v_i;
  logic   vis;
  stage_t dec;

  always_comb begin
    h_i     = int'(h_cnt);
    v_i     = int'(v_cnt);
    vis     = (h_i >= HA0) && (h_i < HA0 + H_ACTIVE) && (v_i >= VA0) && (v_i < VA0 + V_ACTIVE);
    dec     = STAGE_RST;
    dec.hs  = (h_i < H_SYNC) ? HS_POL : ~HS_POL;
    dec.vs  = (v_i < V_SYNC) ? VS_POL : ~VS_POL;
    dec.rdn = ~vis;
    // Addresses wrap outside the visible window; consumers only use them while rdn is low.
    dec.col = COL_W'(h_cnt - HW'(HA0));
    dec.row = ROW_W'(v_cnt - VW'(VA0));
    dec.ls  = vis && (h_i == HA0);
    dec.fs  = vis && (h_i == HA0) && (v_i == VA0);
  end

  stage_t pipe [PIPE+1];
  logic   en_q;

  always_ff @(posedge vga_clk) begin
    if (!clrn) begin
      for (int i = 0; i <= PIPE; i++) pipe[i] <= STAGE_RST;
      en_q <= 1'b0;
    end else begin
      en_q <= pix_en;
      if (pix_en) begin
        pipe[0] <= dec;
        for (int i = 1; i <= PIPE; i++) pipe[i] <= pipe[i-1];
      end
    end
  end

  // Pulse bits ride the pipeline untouched while stalled; only the output view is masked.
  assign row_addr    = pipe[PIPE].row;
  assign col_addr    = pipe[PIPE].col;
  assign rdn         = pipe[PIPE].rdn;
  assign hs          = pipe[PIPE].hs;
  assign vs          = pipe[PIPE].vs;
  assign line_start  = pipe[PIPE].ls & en_q;
  assign frame_start = pipe[PIPE].fs & en_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a 14x7 raster (H 2/2/8/2, V 1/1/4/1), PIPE=2, positive syncs.
module tb_vga_timing_gen;

  logic       vga_clk = 1'b0;
  logic       clrn    = 1'b0;
  logic       pix_en  = 1'b0;
  logic [1:0] row_addr;
  logic [2:0] col_addr;
  logic       rdn, hs, vs, line_start, frame_start;

  always #5 vga_clk = ~vga_clk;

  vga_timing_gen #(
    .H_SYNC(2), .H_BP(2), .H_ACTIVE(8), .H_FP(2),
    .V_SYNC(1), .V_BP(1), .V_ACTIVE(4), .V_FP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .COL_W(3), .ROW_W(2), .PIPE(2)
  ) dut (
    .vga_clk     (vga_clk),
    .clrn        (clrn),
    .pix_en      (pix_en),
    .row_addr    (row_addr),
    .col_addr    (col_addr),
    .rdn         (rdn),
    .hs          (hs),
    .vs          (vs),
    .line_start  (line_start),
    .frame_start (frame_start)
  );

  typedef struct packed {
    logic       rdn;
    logic       hs;
    logic       vs;
    logic       ls;
    logic       fs;
    logic       chk_addr;
    logic [1:0] row;
    logic [2:0] col;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   k     = 0;   // enabled edges since reset release
  bit   win   = 1'b0;
  int   c_hs, c_vs, c_rd, c_ls, c_fs;

  // Output after k enabled edges shows raster position k-3; before that, reset values.
  function automatic exp_t model(input int kk, input bit en_edge);
    exp_t e;
    int   pos, h, v;
    bit   vis;
    e = '{rdn: 1'b1, hs: 1'b0, vs: 1'b0, ls: 1'b0, fs: 1'b0, chk_addr: 1'b1, row: 2'd0, col: 3'd0};
    if (kk >= 3) begin
      pos        = kk - 3;
      h          = pos % 14;
      v          = (pos / 14) % 7;
      vis        = (h >= 4) && (h < 12) && (v >= 2) && (v < 6);
      e.hs       = (h < 2);
      e.vs       = (v < 1);
      e.rdn      = !vis;
      e.chk_addr = vis;
      e.col      = 3'(h - 4);
      e.row      = 2'(v - 2);
      e.ls       = vis && (h == 4) && en_edge;
      e.fs       = e.ls && (v == 2);
    end
    return e;
  endfunction

  task automatic step(input bit en, input bit rn);
    @(negedge vga_clk);
    pix_en = en;
    clrn   = rn;
    @(posedge vga_clk);
    if (!rn) k = 0;
    else if (en) k++;
    exp_q.push_back(model(k, rn && en));
  endtask

  task automatic check_eq(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  initial begin : monitor
    exp_t e;
    bit   bad;
    forever begin
      @(posedge vga_clk);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        bad = (rdn !== e.rdn) || (hs !== e.hs) || (vs !== e.vs) ||
              (line_start !== e.ls) || (frame_start !== e.fs) ||
              (e.chk_addr && ((row_addr !== e.row) || (col_addr !== e.col)));
        n_cmp++;
        if (bad) begin
          n_err++;
          $display("FAIL out_vec t=%0t: got rdn=%b hs=%b vs=%b ls=%b fs=%b row=%0d col=%0d, expected rdn=%b hs=%b vs=%b ls=%b fs=%b row=%0d col=%0d",
                   $time, rdn, hs, vs, line_start, frame_start, row_addr, col_addr,
                   e.rdn, e.hs, e.vs, e.ls, e.fs, e.row, e.col);
        end
        if (win) begin
          c_hs += int'(hs);
          c_vs += int'(vs);
          c_rd += int'(!rdn);
          c_ls += int'(line_start);
          c_fs += int'(frame_start);
        end
      end
    end
  end

  task automatic run_window(input bit alt, input int n);
    c_hs = 0; c_vs = 0; c_rd = 0; c_ls = 0; c_fs = 0;
    #2;
    win = 1'b1;
    for (int i = 0; i < n; i++) step(alt ? (i % 2 == 0) : 1'b1, 1'b1);
    #2;
    win = 1'b0;
  endtask

  initial begin : stimulus
    // Reset held with pix_en high then low: scoreboard expects reset values throughout.
    repeat (3) step(1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b0);
    #1;
    check_eq("reset_rdn", int'(rdn), 1);
    check_eq("reset_hs", int'(hs), 0);
    check_eq("reset_vs", int'(vs), 0);

    // First visible pixel (h=4,v=2 -> position 32) emerges after 35 enabled edges.
    repeat (34) step(1'b1, 1'b1);
    #1;
    check_eq("pre_frame_start", int'(frame_start), 0);
    step(1'b1, 1'b1);
    #1;
    check_eq("first_frame_start", int'(frame_start), 1);
    check_eq("first_line_start", int'(line_start), 1);
    check_eq("first_rdn", int'(rdn), 0);
    check_eq("first_row", int'(row_addr), 0);
    check_eq("first_col", int'(col_addr), 0);

    // One full 98-cycle frame at full rate.
    run_window(1'b0, 98);
    check_eq("frame_hs_cycles", c_hs, 14);
    check_eq("frame_vs_cycles", c_vs, 14);
    check_eq("frame_rdn_low", c_rd, 32);
    check_eq("frame_line_starts", c_ls, 4);
    check_eq("frame_frame_starts", c_fs, 1);

    // Half-rate enable: one frame spans 196 clocks, levels doubled, pulses not.
    run_window(1'b1, 196);
    check_eq("half_hs_cycles", c_hs, 28);
    check_eq("half_vs_cycles", c_vs, 28);
    check_eq("half_rdn_low", c_rd, 64);
    check_eq("half_line_starts", c_ls, 4);
    check_eq("half_frame_starts", c_fs, 1);

    // Run to the middle of visible row 2, then a single-cycle reset.
    for (int i = 0; i < 200 && !(k >= 3 && ((k - 3) / 14) % 7 == 4 && (k - 3) % 14 == 7); i++)
      step(1'b1, 1'b1);
    #1;
    check_eq("mid_row_before_reset", int'(row_addr), 2);
    step(1'b1, 1'b0);
    #1;
    check_eq("midreset_rdn", int'(rdn), 1);
    check_eq("midreset_hs", int'(hs), 0);
    check_eq("midreset_vs", int'(vs), 0);
    check_eq("midreset_row", int'(row_addr), 0);
    check_eq("midreset_col", int'(col_addr), 0);
    repeat (35) step(1'b1, 1'b1);
    #1;
    check_eq("restart_frame_start", int'(frame_start), 1);
    repeat (30) step(1'b1, 1'b1);

    #3;
    check_eq("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
